// File: rtl/log_capture_if.sv
// log_capture_if: bundles the run-control, sample and read-back signals of
// the capture buffer.
//   master : file register / sample source side (drives i_*, observes o_*)
//   slave  : log_capture side (observes i_*, drives o_*)
// Signals: i_samples/i_valid (sample stream), i_run/i_abort (control pulses),
// i_dec/i_pretrig/i_trig_level (capture configuration),
// i_rd_en/i_rd_addr -> o_rd_data/o_rd_valid (read-back),
// o_busy/o_armed/o_full/o_start_addr (status).
interface log_capture_if #(
    parameter int NCH     = 2,
    parameter int NB_SAMP = 8,
    parameter int NB_ADDR = 10,
    parameter int NB_DEC  = 8
);
    logic [NCH*NB_SAMP-1:0] i_samples;
    logic                   i_valid;
    logic                   i_run;
    logic                   i_abort;
    logic [NB_DEC-1:0]      i_dec;
    logic [NB_ADDR-1:0]     i_pretrig;
    logic [NB_SAMP-1:0]     i_trig_level;
    logic                   i_rd_en;
    logic [NB_ADDR-1:0]     i_rd_addr;
    logic [NCH*NB_SAMP-1:0] o_rd_data;
    logic                   o_rd_valid;
    logic                   o_busy;
    logic                   o_armed;
    logic                   o_full;
    logic [NB_ADDR-1:0]     o_start_addr;

    modport master (
        output i_samples, i_valid, i_run, i_abort, i_dec, i_pretrig,
               i_trig_level, i_rd_en, i_rd_addr,
        input  o_rd_data, o_rd_valid, o_busy, o_armed, o_full, o_start_addr
    );

    modport slave (
        input  i_samples, i_valid, i_run, i_abort, i_dec, i_pretrig,
               i_trig_level, i_rd_en, i_rd_addr,
        output o_rd_data, o_rd_valid, o_busy, o_armed, o_full, o_start_addr
    );
endinterface

// File: rtl/log_capture.sv
// log_capture: multi-channel sample logger into one shared RAM with
// decimation, pre-trigger window and a rising level-crossing trigger on
// channel 0. After capture the buffer is read back by logical index
// (0 = oldest sample) with one cycle of read latency.
// Ports:
//   clock   - system clock
//   i_reset - asynchronous reset, active-low
//   bus     - log_capture_if.slave (samples, control, config, read, status)
// Optional feature macro: LOG_TRIGGER_EN. When undefined, the trigger,
// pre-trigger window and ARMED state are unused: i_run goes straight to
// POST and fills RAM_DEPTH-1 words starting at address 0.
module log_capture #(
    parameter int NCH       = 2,
    parameter int NB_SAMP   = 8,
    parameter int RAM_DEPTH = 1024,
    parameter int NB_DEC    = 8
) (
    input  logic          clock,
    input  logic          i_reset,
    log_capture_if.slave  bus
);
    localparam int NB_ADDR = $clog2(RAM_DEPTH);
    localparam int NB_DATA = NCH * NB_SAMP;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [NB_DEC-1:0]   dec_q, dec_d;
    logic [NB_DEC-1:0]   dec_cnt_q, dec_cnt_d;
    logic [NB_ADDR-1:0]  pretrig_q, pretrig_d;
    logic [NB_ADDR-1:0]  wr_ptr_q, wr_ptr_d;
    logic [NB_ADDR-1:0]  cnt_q, cnt_d;      // PRE: samples held; POST: remaining
    logic [NB_ADDR-1:0]  start_q, start_d;
    logic                prev_below_q, prev_below_d;
    logic                busy_q, armed_q, full_q;
    logic                rd_valid_q;
    logic [NB_DATA-1:0]  rd_data_q;
    logic                capturing_s, accept_s, wr_en_s, below_s, rd_ok_s;
    logic [NB_ADDR-1:0]  rd_phys_s;
    logic [NB_DATA-1:0]  mem [RAM_DEPTH];

    // Trigger comparison of channel 0 against the signed level
`ifdef LOG_TRIGGER_EN
    always_comb begin
        below_s = $signed(bus.i_samples[NB_SAMP-1:0]) < $signed(bus.i_trig_level);
    end
`else
    wire unused_trig_s = ^{bus.i_trig_level, bus.i_pretrig};
    always_comb begin
        below_s = 1'b0;
    end
`endif

    // Decide whether this cycle can take a sample; the degenerate PRE/POST
    // cases (nothing left to collect) are state-change-only cycles
    always_comb begin
        capturing_s = ((state_q == ST_PRE) && (pretrig_q != {NB_ADDR{1'b0}})) ||
                      (state_q == ST_ARMED) ||
                      ((state_q == ST_POST) && (cnt_q != {NB_ADDR{1'b0}}));
        accept_s    = capturing_s && bus.i_valid && (dec_cnt_q == {NB_DEC{1'b0}});
        wr_en_s     = accept_s && !bus.i_abort;
        rd_ok_s     = (state_q == ST_IDLE) || (state_q == ST_DONE);
        rd_phys_s   = start_q + bus.i_rd_addr;
    end

    // Next-state and datapath update logic
    always_comb begin
        state_d      = state_q;
        dec_d        = dec_q;
        dec_cnt_d    = dec_cnt_q;
        pretrig_d    = pretrig_q;
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = cnt_q;
        start_d      = start_q;
        prev_below_d = prev_below_q;

        if (capturing_s && bus.i_valid) begin
            if (dec_cnt_q == {NB_DEC{1'b0}}) begin
                dec_cnt_d = dec_q - NB_DEC'(1);
            end else begin
                dec_cnt_d = dec_cnt_q - NB_DEC'(1);
            end
        end else begin
            dec_cnt_d = dec_cnt_q;
        end

        if (wr_en_s) begin
            wr_ptr_d = wr_ptr_q + NB_ADDR'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (bus.i_abort) begin
            state_d = ST_IDLE;
            start_d = {NB_ADDR{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.i_run) begin
                        dec_d        = (bus.i_dec == {NB_DEC{1'b0}}) ? NB_DEC'(1) : bus.i_dec;
                        dec_cnt_d    = {NB_DEC{1'b0}};
                        wr_ptr_d     = {NB_ADDR{1'b0}};
                        // No predecessor yet: the first ARMED sample may trigger
                        prev_below_d = 1'b1;
`ifdef LOG_TRIGGER_EN
                        pretrig_d    = bus.i_pretrig;
                        cnt_d        = {NB_ADDR{1'b0}};
                        state_d      = ST_PRE;
`else
                        pretrig_d    = {NB_ADDR{1'b0}};
                        start_d      = {NB_ADDR{1'b0}};
                        cnt_d        = NB_ADDR'(RAM_DEPTH - 1);
                        state_d      = ST_POST;
`endif
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_PRE: begin
                    if (pretrig_q == {NB_ADDR{1'b0}}) begin
                        state_d = ST_ARMED;
                    end else if (accept_s) begin
                        cnt_d        = cnt_q + NB_ADDR'(1);
                        prev_below_d = below_s;
                        if (cnt_q + NB_ADDR'(1) == pretrig_q) begin
                            state_d = ST_ARMED;
                        end else begin
                            state_d = ST_PRE;
                        end
                    end else begin
                        state_d = ST_PRE;
                    end
                end
                ST_ARMED: begin
                    if (accept_s && prev_below_q && !below_s) begin
                        start_d = wr_ptr_q - pretrig_q;
                        // RAM_DEPTH - pretrig - 1, since RAM_DEPTH is 2**NB_ADDR
                        cnt_d   = ~pretrig_q;
                        state_d = ST_POST;
                    end else if (accept_s) begin
                        prev_below_d = below_s;
                    end else begin
                        state_d = ST_ARMED;
                    end
                end
                ST_POST: begin
                    if (cnt_q == {NB_ADDR{1'b0}}) begin
                        state_d = ST_DONE;
                    end else if (accept_s) begin
                        cnt_d = cnt_q - NB_ADDR'(1);
                        if (cnt_q == NB_ADDR'(1)) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_POST;
                        end
                    end else begin
                        state_d = ST_POST;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State, configuration and status registers
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q      <= ST_IDLE;
            dec_q        <= {NB_DEC{1'b0}};
            dec_cnt_q    <= {NB_DEC{1'b0}};
            pretrig_q    <= {NB_ADDR{1'b0}};
            wr_ptr_q     <= {NB_ADDR{1'b0}};
            cnt_q        <= {NB_ADDR{1'b0}};
            start_q      <= {NB_ADDR{1'b0}};
            prev_below_q <= 1'b0;
            busy_q       <= 1'b0;
            armed_q      <= 1'b0;
            full_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dec_q        <= dec_d;
            dec_cnt_q    <= dec_cnt_d;
            pretrig_q    <= pretrig_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            start_q      <= start_d;
            prev_below_q <= prev_below_d;
            busy_q       <= (state_d == ST_PRE) || (state_d == ST_ARMED) || (state_d == ST_POST);
            armed_q      <= (state_d == ST_ARMED);
            full_q       <= (state_d == ST_DONE);
        end
    end

    // RAM write port; contents are not reset
    always_ff @(posedge clock) begin
        if (wr_en_s) begin
            mem[wr_ptr_q] <= bus.i_samples;
        end
    end

    // Registered read port, honoured only while not capturing
    always_ff @(posedge clock or negedge i_reset) begin
        if (!i_reset) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= {NB_DATA{1'b0}};
        end else begin
            rd_valid_q <= bus.i_rd_en && rd_ok_s;
            if (bus.i_rd_en && rd_ok_s) begin
                rd_data_q <= mem[rd_phys_s];
            end
        end
    end

    assign bus.o_rd_data    = rd_data_q;
    assign bus.o_rd_valid   = rd_valid_q;
    assign bus.o_busy       = busy_q;
    assign bus.o_armed      = armed_q;
    assign bus.o_full       = full_q;
    assign bus.o_start_addr = start_q;
endmodule

// File: tb/tb_log_capture.sv
// tb_log_capture: directed, table-driven bench for log_capture.
// Each capture streams a ramp (ch0 = ramp, ch1 = ch0 ^ 8'hA5) beginning one
// idle cycle after i_run, waits (bounded) for o_full, then applies a table of
// read-back vectors. Expected values are hand-computed for both builds.
module tb_log_capture;
    localparam int NCH       = 2;
    localparam int NB_SAMP   = 8;
    localparam int RAM_DEPTH = 1024;
    localparam int NB_ADDR   = 10;
    localparam int NB_DEC    = 8;
`ifdef LOG_TRIGGER_EN
    localparam logic TRIG = 1'b1;
`else
    localparam logic TRIG = 1'b0;
`endif

    typedef struct {
        logic [9:0]  idx;
        logic [15:0] exp;
    } rd_vec_t;

    logic clock = 1'b0;
    logic i_reset;
    int   tests = 0;
    int   fails = 0;
    int   ncyc;

    log_capture_if #(.NCH(NCH), .NB_SAMP(NB_SAMP), .NB_ADDR(NB_ADDR), .NB_DEC(NB_DEC)) bus ();

    log_capture #(.NCH(NCH), .NB_SAMP(NB_SAMP), .RAM_DEPTH(RAM_DEPTH), .NB_DEC(NB_DEC)) dut (
        .clock   (clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_samples    = 16'h0000;
        bus.i_valid      = 1'b0;
        bus.i_run        = 1'b0;
        bus.i_abort      = 1'b0;
        bus.i_dec        = 8'd1;
        bus.i_pretrig    = 10'd0;
        bus.i_trig_level = 8'h00;
        bus.i_rd_en      = 1'b0;
        bus.i_rd_addr    = 10'd0;
    endtask

    task automatic set_sample(input logic [7:0] c0);
        bus.i_valid   = 1'b1;
        bus.i_samples = {c0 ^ 8'hA5, c0};
    endtask

    // i_run pulse followed by one cycle with no valid sample
    task automatic start_run(input logic [7:0] dec, input logic [9:0] pre, input logic [7:0] lvl);
        bus.i_run        = 1'b1;
        bus.i_dec        = dec;
        bus.i_pretrig    = pre;
        bus.i_trig_level = lvl;
        tick();
        bus.i_run = 1'b0;
        tick();
    endtask

    // Stream a ramp until o_full, at most 5000 cycles; n = cycles driven
    task automatic capture(input logic [7:0] start, output int n);
        n = 0;
        while (!bus.o_full && n < 5000) begin
            set_sample(start + 8'(n));
            tick();
            n++;
        end
        bus.i_valid = 1'b0;
    endtask

    task automatic do_read(input string name, input logic [9:0] idx, input logic [15:0] exp);
        bus.i_rd_en   = 1'b1;
        bus.i_rd_addr = idx;
        tick();
        bus.i_rd_en = 1'b0;
        check({name, "_valid"}, 32'(bus.o_rd_valid), 32'd1);
        check({name, "_data"}, 32'(bus.o_rd_data), 32'(exp));
    endtask

    rd_vec_t tab_a[4];
    rd_vec_t tab_b[5];
    rd_vec_t tab_c[4];
    rd_vec_t tab_d[3];

    initial begin
`ifdef LOG_TRIGGER_EN
        tab_a[0] = '{10'd0,    16'hB510};
        tab_a[1] = '{10'd5,    16'hB015};
        tab_a[2] = '{10'd255,  16'hAA0F};
        tab_a[3] = '{10'd1023, 16'hAA0F};
`else
        tab_a[0] = '{10'd0,    16'hA500};
        tab_a[1] = '{10'd5,    16'hA005};
        tab_a[2] = '{10'd255,  16'h5AFF};
        tab_a[3] = '{10'd1022, 16'h5BFE};
`endif
        tab_b[0] = '{10'd0, 16'h993C};
        tab_b[1] = '{10'd1, 16'h983D};
        tab_b[2] = '{10'd2, 16'h9B3E};
        tab_b[3] = '{10'd3, 16'h9A3F};
        tab_b[4] = '{10'd4, 16'hE540};
        tab_c[0] = '{10'd0, 16'hDA7F};
        tab_c[1] = '{10'd1, 16'h2782};
        tab_c[2] = '{10'd2, 16'h2085};
        tab_c[3] = '{10'd3, 16'h2D88};
        tab_d[0] = '{10'd0,  16'h9530};
        tab_d[1] = '{10'd9,  16'h9C39};
        tab_d[2] = '{10'd10, 16'h389D};

        // Reset state
        idle_inputs();
        i_reset = 1'b0;
        #12;
        check("rst_busy",  32'(bus.o_busy),       32'd0);
        check("rst_armed", 32'(bus.o_armed),      32'd0);
        check("rst_full",  32'(bus.o_full),       32'd0);
        check("rst_start", 32'(bus.o_start_addr), 32'd0);
        check("rst_rdv",   32'(bus.o_rd_valid),   32'd0);
        check("rst_rdd",   32'(bus.o_rd_data),    32'd0);
        i_reset = 1'b1;
        tick();

        // Capture A: dec=1, pretrig=0, level 0x10, ramp from 0
        start_run(8'd1, 10'd0, 8'h10);
        check("A_busy", 32'(bus.o_busy), 32'd1);
        capture(8'h00, ncyc);
        check("A_cycles", 32'(ncyc), TRIG ? 32'd1040 : 32'd1023);
        check("A_full",   32'(bus.o_full), 32'd1);
        check("A_busy_done", 32'(bus.o_busy), 32'd0);
        check("A_start", 32'(bus.o_start_addr), TRIG ? 32'd16 : 32'd0);
        // Samples offered in DONE must not be stored
        for (int i = 0; i < 3; i++) begin
            set_sample(8'hEE);
            tick();
        end
        bus.i_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            do_read($sformatf("A_rd%0d", i), tab_a[i].idx, tab_a[i].exp);
        end
        tick();
        check("A_rdv_drop", 32'(bus.o_rd_valid), 32'd0);

`ifdef LOG_TRIGGER_EN
        // Capture B: pretrig=4, level 0x40
        start_run(8'd1, 10'd4, 8'h40);
        capture(8'h00, ncyc);
        check("B_cycles", 32'(ncyc), 32'd1084);
        check("B_start",  32'(bus.o_start_addr), 32'd60);
        for (int i = 0; i < 5; i++) begin
            do_read($sformatf("B_rd%0d", i), tab_b[i].idx, tab_b[i].exp);
        end
`endif

        // Capture C: dec=3, level 0x80 (-128), ramp from 0x7F
        start_run(8'd3, 10'd0, 8'h80);
        capture(8'h7F, ncyc);
        check("C_cycles", 32'(ncyc), TRIG ? 32'd3070 : 32'd3067);
        check("C_start",  32'(bus.o_start_addr), 32'd0);
        for (int i = 0; i < 4; i++) begin
            do_read($sformatf("C_rd%0d", i), tab_c[i].idx, tab_c[i].exp);
        end

        // Capture D: dec=0, no crossing; ignored run, read while busy, abort
        start_run(8'd0, 10'd0, 8'h7F);
        check("D_armed", 32'(bus.o_armed), 32'(TRIG));
        for (int k = 0; k < 10; k++) begin
            set_sample(8'h30 + 8'(k));
            bus.i_run   = (k == 4);
            bus.i_rd_en = (k == 6);
            tick();
            if (k == 6) begin
                check("D_rd_busy", 32'(bus.o_rd_valid), 32'd0);
            end
        end
        bus.i_run   = 1'b0;
        bus.i_rd_en = 1'b0;
        check("D_armed_end", 32'(bus.o_armed), 32'(TRIG));
        check("D_full_end",  32'(bus.o_full), 32'd0);
        set_sample(8'h3A);
        bus.i_abort = 1'b1;
        tick();
        bus.i_abort = 1'b0;
        bus.i_valid = 1'b0;
        check("D_abort_busy",  32'(bus.o_busy),  32'd0);
        check("D_abort_armed", 32'(bus.o_armed), 32'd0);
        check("D_abort_start", 32'(bus.o_start_addr), 32'd0);
        for (int i = 0; i < 3; i++) begin
            do_read($sformatf("D_rd%0d", i), tab_d[i].idx, tab_d[i].exp);
        end

        // Run and abort together: abort wins
        bus.i_run   = 1'b1;
        bus.i_abort = 1'b1;
        tick();
        bus.i_run   = 1'b0;
        bus.i_abort = 1'b0;
        check("F_runabort_busy", 32'(bus.o_busy), 32'd0);
        tick();
        check("F_runabort_busy2", 32'(bus.o_busy), 32'd0);

        // Asynchronous reset in the middle of a capture
        start_run(8'd1, 10'd0, 8'h7F);
        for (int k = 0; k < 5; k++) begin
            set_sample(8'(k));
            tick();
        end
        check("G_busy_pre", 32'(bus.o_busy), 32'd1);
        #2;
        i_reset = 1'b0;
        #1;
        check("G_busy",  32'(bus.o_busy),     32'd0);
        check("G_armed", 32'(bus.o_armed),    32'd0);
        check("G_full",  32'(bus.o_full),     32'd0);
        check("G_rdd",   32'(bus.o_rd_data),  32'd0);
        check("G_rdv",   32'(bus.o_rd_valid), 32'd0);
        idle_inputs();
        #3;
        i_reset = 1'b1;
        tick();
        tick();
        check("G_busy_after", 32'(bus.o_busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
